// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  function automatic logic is_bcd_digit(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_serial_adder_ctrl_digit_add.sv
// Single-digit BCD add stage: da + db + ci with decimal correction.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t da,
  input  bcd_digit_t db,
  input  logic       ci,
  output bcd_digit_t digit,
  output logic       co
);

  logic [4:0] t_s;

  // Binary sum, then add 6 when it exceeds nine to wrap into the next decade
  always_comb begin
    t_s = {1'b0, da} + {1'b0, db} + {4'b0000, ci};
    if (t_s > {1'b0, BCD_MAX}) begin
      digit = t_s[3:0] + BCD_CORR;
      co    = 1'b1;
    end else begin
      digit = t_s[3:0];
      co    = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial packed-BCD adder controller, LSD first, one digit per clock.
// Optional macro BCD_INVALID_CHECK_EN adds a sticky non-BCD input flag output.
module bcd_serial_adder_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NDIGITS-1:0] a,
  input  logic [4*NDIGITS-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NDIGITS-1:0] sum,
  output logic                 cout
`ifdef BCD_INVALID_CHECK_EN
  ,
  output logic                 invalid
`endif
);

  localparam int W     = 4 * NDIGITS;
  localparam int CNT_W = $clog2(NDIGITS) + 1;
  localparam int DW    = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIGITS - 1);

  ctrl_state_t      state_q, state_d;
  logic [W-1:0]     a_sr_q, a_sr_d;
  logic [W-1:0]     b_sr_q, b_sr_d;
  logic [W-1:0]     sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  bcd_digit_t       digit_s;
  logic             co_s;

  bcd_digit_add u_digit_add (
    .da    (a_sr_q[3:0]),
    .db    (b_sr_q[3:0]),
    .ci    (carry_q),
    .digit (digit_s),
    .co    (co_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, datapath and output-register next values
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ADD;
          a_sr_d   = a;
          b_sr_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sr_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        // New digit enters at the top so the LSD ends up in [3:0] after NDIGITS shifts
        a_sr_d   = a_sr_q >> DW;
        b_sr_d   = b_sr_q >> DW;
        sum_sr_d = (sum_sr_q >> DW) | (W'(digit_s) << (W - DW));
        carry_d  = co_s;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          sum_d   = sum_sr_d;
          cout_d  = co_s;
        end else begin
          state_d = ADD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef BCD_INVALID_CHECK_EN
  logic inv_sticky_q, inv_sticky_d;
  logic invalid_q, invalid_d;

  // Sticky non-BCD detect over the operation, published with the result
  always_comb begin
    inv_sticky_d = inv_sticky_q;
    invalid_d    = invalid_q;
    if ((state_q == IDLE) && start) begin
      inv_sticky_d = 1'b0;
    end else if (state_q == ADD) begin
      inv_sticky_d = inv_sticky_q | ~is_bcd_digit(a_sr_q[3:0]) | ~is_bcd_digit(b_sr_q[3:0]);
      if (cnt_q == LAST_CNT) begin
        invalid_d = inv_sticky_d;
      end else begin
        invalid_d = invalid_q;
      end
    end else begin
      inv_sticky_d = inv_sticky_q;
    end
  end

  // Invalid-flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_sticky_q <= 1'b0;
      invalid_q    <= 1'b0;
    end else begin
      inv_sticky_q <= inv_sticky_d;
      invalid_q    <= invalid_d;
    end
  end

  assign invalid = invalid_q;
`endif

endmodule
